// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle KGP-miniRISC control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory ready handshakes, global stall, sticky memory-timeout error state.
module multicycle_ctrl_fsm #(
    parameter int OPC_W   = 6,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             stall,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_inc,
    output logic             branch_en,
    output logic             alu_en,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             jump_addr,
    output logic             lbl_sel,
    output logic [3:0]       brh_sel,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_IMM, C_LOAD, C_STORE, C_BR, C_BRWB
    } class_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t           st;
    class_t           cls;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       op6;

    class_t     dec_cls;
    logic [1:0] dec_reg_dst;
    logic [1:0] dec_m2r;
    logic       dec_ja;
    logic       dec_lbl;
    logic [3:0] dec_brh;
    logic [2:0] dec_aop;

    logic waiting;
    logic ready;
    logic advance;
    logic expire;
    logic fire;

    assign op6 = opcode[OPC_W-1 -: 6];

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        dec_cls     = C_ALU;
        dec_reg_dst = 2'b00;
        dec_m2r     = 2'b10;
        dec_ja      = 1'b0;
        dec_lbl     = 1'b0;
        dec_brh     = 4'b0000;
        dec_aop     = 3'b001;
        if (op6[5:3] == 3'b100) begin
            dec_cls = (op6 == 6'b100101) ? C_BRWB : C_BR;
            dec_m2r = 2'b00;
            dec_brh = {1'b1, op6[2:0]};
            dec_ja  = (op6 == 6'b100001);
            dec_lbl = (op6 inside {6'b100010, 6'b100011, 6'b100100});
            if (op6 == 6'b100101) dec_reg_dst = 2'b10;
        end else begin
            case (op6)
                6'b010000: dec_aop = 3'b000;
                6'b000000: begin
                    dec_cls     = C_LOAD;
                    dec_reg_dst = 2'b01;
                    dec_m2r     = 2'b01;
                    dec_aop     = 3'b011;
                end
                6'b000001: begin
                    dec_cls = C_STORE;
                    dec_m2r = 2'b01;
                    dec_aop = 3'b011;
                end
                6'b110010: begin dec_cls = C_IMM; dec_aop = 3'b100; end
                6'b110001: begin dec_cls = C_IMM; dec_aop = 3'b010; end
                default: ;
            endcase
        end
    end

    // A ready seen during stall is ignored; the memory keeps it high until accepted.
    assign waiting = (st == FETCH) || (st == MEM);
    assign ready   = (st == FETCH) ? imem_ready : dmem_ready;
    assign advance = !stall && (waiting ? ready : (st inside {DECODE, EXEC, WB}));
    assign expire  = waiting && !ready && (TIMEOUT != 0) && (wait_cnt == TO_CNT);

    // NOTE: strobes are Mealy so they can be squashed by stall in the same cycle.
    assign fire       = !rst && advance;
    assign imem_req   = !rst && (st == FETCH);
    assign dmem_req   = !rst && (st == MEM);
    assign mem_read   = dmem_req && (cls == C_LOAD);
    assign mem_write  = dmem_req && (cls == C_STORE);
    assign ir_write   = fire && (st == FETCH);
    assign pc_inc     = fire && (st == FETCH);
    assign alu_en     = fire && (st == EXEC) && (cls inside {C_ALU, C_IMM, C_LOAD, C_STORE});
    assign branch_en  = fire && (st == EXEC) && (cls inside {C_BR, C_BRWB});
    assign reg_write  = fire && (st == WB);
    assign instr_done = fire && ((st == WB) || (st == EXEC && cls == C_BR) ||
                                 (st == MEM && cls == C_STORE));
    assign state      = st;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= FETCH;
            cls        <= C_ALU;
            wait_cnt   <= '0;
            bus_err    <= 1'b0;
            reg_dst    <= 2'b00;
            mem_to_reg <= 2'b00;
            jump_addr  <= 1'b0;
            lbl_sel    <= 1'b0;
            brh_sel    <= 4'b0000;
            alu_op     <= 3'b000;
        end else begin
            case (st)
                FETCH, MEM: begin
                    if (advance) begin
                        wait_cnt <= '0;
                        if (st == FETCH)        st <= DECODE;
                        else if (cls == C_LOAD) st <= WB;
                        else                    st <= FETCH;
                    end else if (expire) begin
                        wait_cnt <= '0;
                        st       <= ERROR;
                        bus_err  <= 1'b1;
                    end else if (!ready && TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: if (!stall) begin
                    st         <= EXEC;
                    cls        <= dec_cls;
                    reg_dst    <= dec_reg_dst;
                    mem_to_reg <= dec_m2r;
                    jump_addr  <= dec_ja;
                    lbl_sel    <= dec_lbl;
                    brh_sel    <= dec_brh;
                    alu_op     <= dec_aop;
                end
                EXEC: if (!stall) begin
                    case (cls)
                        C_LOAD, C_STORE: st <= MEM;
                        C_BR:            st <= FETCH;
                        default:         st <= WB;
                    endcase
                end
                WB:      if (!stall) st <= FETCH;
                ERROR:   st <= ERROR;
                default: st <= FETCH;
            endcase
        end
    end

endmodule
